// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient loader.
// Holds the target's register addresses, bus/data widths and the loader state enum.
package biquad8_pkg;

  localparam int unsigned BQ_ADR_W   = 7;
  localparam int unsigned BQ_DAT_W   = 32;
  localparam int unsigned BQ_SEL_W   = 4;
  localparam int unsigned BQ_COEFF_W = 18;
  localparam int unsigned BQ_TMO_W   = 10;

  // Coefficient target register map
  localparam logic [BQ_ADR_W-1:0] BQ_ADR_UPDATE    = 7'h00;
  localparam logic [BQ_ADR_W-1:0] BQ_ADR_ZFIR      = 7'h04;
  localparam logic [BQ_ADR_W-1:0] BQ_ADR_POLE_BASE = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } bq_load_state_t;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// WISHBONE initiator that drains an 18-bit coefficient stream into a biquad8
// coefficient target: NZERO writes to 0x04, NPOLE writes each to 0x10/0x14/0x18/0x1C,
// then an optional update write (dat 1) to 0x00.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   start_i, update_i           start pulse; update_i sampled at start
//   s_coeff_tdata/tvalid/tready coefficient stream (ready only while fetching)
//   wb_cyc_o/stb_o/we_o         WISHBONE control (write-only initiator)
//   wb_adr_o/dat_o/sel_o        write address, data and byte select
//   wb_ack_i/err_i/rty_i        target responses; wb_dat_i is unused
//   busy_o, done_o, err_o       status: in progress, completion pulse, sticky abort
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int unsigned NZERO   = 2,
  parameter int unsigned NPOLE   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        update_i,
  input  logic [17:0] s_coeff_tdata,
  input  logic        s_coeff_tvalid,
  output logic        s_coeff_tready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [6:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic [31:0] wb_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned ZW = ($clog2(NZERO + 1) < 1) ? 1 : $clog2(NZERO + 1);
  localparam int unsigned BW = (NPOLE < 2) ? 1 : $clog2(NPOLE);

  localparam logic [ZW-1:0]       Z_END    = ZW'(NZERO);
  localparam logic [BW-1:0]       B_LAST   = BW'(NPOLE - 1);
  localparam logic [BQ_TMO_W-1:0] TMO_LAST = BQ_TMO_W'(TIMEOUT - 1);

  bq_load_state_t state_q, state_d;

  logic [ZW-1:0]         zidx_q, zidx_d;
  logic [1:0]            pole_q, pole_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [BQ_TMO_W-1:0]   tmo_q, tmo_d;
  logic                  upd_q, upd_d;
  logic [BQ_COEFF_W-1:0] coeff_q, coeff_d;

  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic [BQ_ADR_W-1:0]   adr_q, adr_d;
  logic [BQ_DAT_W-1:0]   dat_q, dat_d;
  logic [BQ_SEL_W-1:0]   sel_q, sel_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic hs;
  logic err_hit, ack_hit, rty_hit, tmo_hit;
  logic last_wr;
  logic rty_drop;
  logic unused_dat;

  assign unused_dat = ^wb_dat_i;

  // Responses only count while the strobe is actually out; priority err > ack > rty
  assign hs      = (state_q == ST_FETCH) & tready_q & s_coeff_tvalid;
  assign err_hit = stb_q & wb_err_i;
  assign ack_hit = stb_q & wb_ack_i & ~wb_err_i;
  assign rty_hit = stb_q & wb_rty_i & ~wb_ack_i & ~wb_err_i;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign last_wr = (zidx_q == Z_END) & (pole_q == 2'd3) & (beat_q == B_LAST);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, sequence counters and next values of the registered outputs
  always_comb begin
    state_d  = state_q;
    zidx_d   = zidx_q;
    pole_d   = pole_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    upd_d    = upd_q;
    coeff_d  = coeff_q;
    err_d    = err_q;
    rty_drop = 1'b0;
    adr_d    = '0;
    dat_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          zidx_d  = '0;
          pole_d  = '0;
          beat_d  = '0;
          upd_d   = update_i;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (hs) begin
          coeff_d = s_coeff_tdata;
          tmo_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE, ST_UPDATE: begin
        // Counter runs across retries and saturates at the abort point
        if (!tmo_hit) begin
          tmo_d = tmo_q + 1'b1;
        end
        if (err_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_hit) begin
          tmo_d = '0;
          if (state_q == ST_UPDATE) begin
            state_d = ST_DONE;
          end else begin
            if (zidx_q != Z_END) begin
              zidx_d = zidx_q + 1'b1;
            end else if (beat_q == B_LAST) begin
              beat_d = '0;
              pole_d = pole_q + 2'd1;
            end else begin
              beat_d = beat_q + 1'b1;
            end
            if (last_wr) begin
              state_d = upd_q ? ST_UPDATE : ST_DONE;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end else if (rty_hit) begin
          rty_drop = 1'b1;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    cyc_d = (state_d == ST_WRITE) || (state_d == ST_UPDATE);
    stb_d = cyc_d & ~rty_drop;
    sel_d = cyc_d ? 4'hF : 4'h0;
    if (state_d == ST_WRITE) begin
      adr_d = (zidx_d != Z_END) ? BQ_ADR_ZFIR
                                : BQ_ADR_POLE_BASE + {3'b000, pole_d, 2'b00};
      dat_d = BQ_DAT_W'(coeff_d);
    end else if (state_d == ST_UPDATE) begin
      adr_d = BQ_ADR_UPDATE;
      dat_d = BQ_DAT_W'(1);
    end
    tready_d = (state_d == ST_FETCH);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      zidx_q   <= '0;
      pole_q   <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      upd_q    <= 1'b0;
      coeff_q  <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      zidx_q   <= zidx_d;
      pole_q   <= pole_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      upd_q    <= upd_d;
      coeff_q  <= coeff_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign s_coeff_tready = tready_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = stb_q;
  assign wb_we_o        = cyc_q;
  assign wb_adr_o       = adr_q;
  assign wb_dat_o       = dat_q;
  assign wb_sel_o       = sel_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
